// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // LO after a divide by zero is every bit set to this value, whatever WIDTH is.
  localparam logic DIV0_LO_BIT = 1'b1;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  mode_e                mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    diff      = rem_shift - {1'b0, operand};
    acc_next  = {add_sum, acc[WIDTH-1:1]};
    if (mode == MODE_DIV) begin
      // Top bit of diff set means the trial subtraction borrowed: restore.
      if (diff[WIDTH]) acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_next = {diff[WIDTH-1:0],      acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative multiply/divide unit owning HI/LO: 33 busy cycles per operation.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mul0_div1,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  mode_e              mode;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // The most negative value maps onto itself, read as an unsigned magnitude.
  assign mag_a = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b = (signed_op && b[WIDTH-1]) ? -b : b;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != ST_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_next)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state including HI/LO and operand copies is cleared; there are no arrays here to leave unreset.
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      a_raw       <= '0;
      mode        <= MODE_MUL;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (we_hi) hi <= wd;
          if (we_lo) lo <= wd;
          if (start && !abort) begin
            state <= ST_CALC;
            cnt   <= '0;
            acc   <= {{WIDTH{1'b0}}, mag_a};
            opnd  <= mag_b;
            a_raw <= a;
            mode  <= mode_e'(mul0_div1);
            neg_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= signed_op & a[WIDTH-1];
            dbz   <= mul0_div1 && (b == '0);
          end
        end
        ST_CALC: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!abort) begin
            done <= 1'b1;
            if (mode == MODE_MUL) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (dbz) begin
              hi          <= a_raw;
              lo          <= {WIDTH{DIV0_LO_BIT}};
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit against a plain-arithmetic reference model.
module tb_muldiv_iter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mul0_div1 = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;
  logic        we_hi = 1'b0;
  logic        we_lo = 1'b0;
  logic [31:0] wd = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_iter_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mul0_div1   (mul0_div1),
    .signed_op   (signed_op),
    .a           (a),
    .b           (b),
    .abort       (abort),
    .we_hi       (we_hi),
    .we_lo       (we_lo),
    .wd          (wd),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS mult/multu/div/divu semantics via 64-bit arithmetic.
  function automatic void model(input logic md, input logic sg, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] rh,
                                output logic [31:0] rl, output logic rz);
    logic signed [63:0] sx, sy, sp, sq, sr;
    logic [63:0] up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    rz = 1'b0;
    if (!md) begin
      if (sg) begin
        sp = sx * sy;
        rh = sp[63:32];
        rl = sp[31:0];
      end else begin
        up = {32'b0, x} * {32'b0, y};
        rh = up[63:32];
        rl = up[31:0];
      end
    end else if (y == 32'd0) begin
      rz = 1'b1;
      rh = x;
      rl = 32'hFFFF_FFFF;
    end else if (sg) begin
      sq = sx / sy;
      sr = sx % sy;
      rh = sr[31:0];
      rl = sq[31:0];
    end else begin
      rh = x % y;
      rl = x / y;
    end
  endfunction

  // Issue one operation, optionally with an mtlo attempt while busy (wlo_cyc > 0)
  // or an mthi in the same cycle as start (whi_at_start).
  task automatic run_op(input logic md, input logic sg, input logic [31:0] oa,
                        input logic [31:0] ob, input string tag,
                        input int wlo_cyc, input logic whi_at_start);
    logic [31:0] eh, el;
    logic ez;
    int cyc, ndone;
    model(md, sg, oa, ob, eh, el, ez);
    @(negedge clk);
    start = 1'b1; mul0_div1 = md; signed_op = sg; a = oa; b = ob;
    we_hi = whi_at_start; wd = 32'h5A5A_0F0F;
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0;
    if (whi_at_start) begin
      check({tag, "_hi_write_with_start"}, hi, 32'h5A5A_0F0F);
      exp_hi = 32'h5A5A_0F0F;
    end
    cyc = 0;
    ndone = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (done === 1'b1) ndone++;
      we_lo = (cyc == wlo_cyc);
      wd = 32'hDEAD_BEEF;
      if (wlo_cyc > 0 && cyc == wlo_cyc + 1) check({tag, "_lo_kept_busy"}, lo, exp_lo);
      @(negedge clk);
    end
    we_lo = 1'b0;
    check({tag, "_busy_cycles"}, cyc, 33);
    check({tag, "_early_done"}, ndone, 0);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_dbz"}, div_by_zero, ez);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    check({tag, "_done_pulse"}, {done, div_by_zero}, 2'b00);
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic ez;
    int ndone;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, div_by_zero, hi, lo}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", busy, 1'b0);

    // Directed arithmetic cases
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7", 0, 1'b0);
    check("mult_neg3x7_hi_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0, 1'b0);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1", 0, 1'b0);
    check("mult_m1xm1_const", {hi, lo}, 64'h0000_0000_0000_0001);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", 0, 1'b0);
    check("div_neg7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(1'b1, 1'b0, 32'd100, 32'd7, "divu_100_7", 0, 1'b0);
    check("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_minint_m1", 0, 1'b0);
    check("div_minint_m1_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(1'b1, 1'b0, 32'h1234_5678, 32'd0, "divu_by_zero", 0, 1'b0);
    check("divu_by_zero_const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(1'b1, 1'b1, 32'h8765_4321, 32'd0, "div_by_zero", 0, 1'b0);

    // mthi / mtlo in IDLE
    @(negedge clk);
    we_hi = 1'b1; wd = 32'hA5A5_A5A5;
    @(negedge clk);
    we_hi = 1'b0;
    check("mthi_idle", hi, 32'hA5A5_A5A5);
    we_lo = 1'b1; wd = 32'h0BAD_F00D;
    @(negedge clk);
    we_lo = 1'b0;
    check("mtlo_idle", lo, 32'h0BAD_F00D);
    exp_hi = 32'hA5A5_A5A5;
    exp_lo = 32'h0BAD_F00D;

    // mtlo while busy is ignored; mthi with start lands, then result overwrites
    run_op(1'b0, 1'b0, 32'd1000, 32'd3000, "mtlo_busy", 3, 1'b0);
    run_op(1'b1, 1'b0, 32'd77, 32'd5, "mthi_with_start", 0, 1'b1);

    // Second start during busy is ignored
    model(1'b0, 1'b0, 32'd1234, 32'd5678, eh, el, ez);
    @(negedge clk);
    start = 1'b1; mul0_div1 = 1'b0; signed_op = 1'b0; a = 32'd1234; b = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; mul0_div1 = 1'b1; signed_op = 1'b1; a = 32'd999; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("second_start_done_count", ndone, 1);
    check("second_start_result", {hi, lo}, {eh, el});
    check("second_start_idle", busy, 1'b0);
    exp_hi = eh;
    exp_lo = el;

    // Abort at busy cycle 10
    @(negedge clk);
    start = 1'b1; mul0_div1 = 1'b1; signed_op = 1'b0; a = 32'd5000; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_low", busy, 1'b0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    check("abort_hilo_kept", {hi, lo}, {exp_hi, exp_lo});

    // abort together with start in IDLE drops the start
    start = 1'b1; abort = 1'b1; a = 32'd6; b = 32'd7; mul0_div1 = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_with_start_idle", busy, 1'b0);
    repeat (40) @(negedge clk);
    check("abort_with_start_hilo", {hi, lo, done}, {exp_hi, exp_lo, 1'b0});

    // Randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb,
             $sformatf("rand%0d", i), 0, 1'b0);
    end

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; mul0_div1 = 1'b0; signed_op = 1'b1; a = 32'hFFFF_0000; b = 32'd12345;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_calc", {busy, done, hi, lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, "after_rst_div", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
Iterative multiply/divide responder serving the pipeline's mult/multu/div/divu, mfhi/mflo and mthi/mtlo operations. The execute stage issues a start pulse with operands. The unit owns the HI/LO architectural registers and returns a busy level, which the hazard unit uses to stall mfhi/mflo and any new start. It replaces the single-cycle combinational mul/div path with a radix-2 engine of 33 cycles per operation.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
mul0_div1  input  1  0 = multiply, 1 = divide; sampled with start
signed_op  input  1  1 = signed (mult/div), 0 = unsigned (multu/divu); sampled with start
a  input  WIDTH  multiplicand or dividend (rs); sampled with start
b  input  WIDTH  multiplier or divisor (rt); sampled with start
abort  input  1  synchronous cancel of an in-flight operation (pipeline flush)
we_hi  input  1  mthi write strobe
we_lo  input  1  mtlo write strobe
wd  input  WIDTH  mthi/mtlo write data
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when HI/LO are updated by an operation
div_by_zero  output  1  pulses with done when a divide had b == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0, all operand/working registers cleared.
- States:
  - IDLE -> CALC on start.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- Timing, with start sampled at edge E0:
  - At E0: magnitudes |a|, |b| are latched when signed_op=1 (raw values otherwise), along with the result-sign flags.
  - Edges E1..E32: one iteration per edge.
  - Edge E33: sign correction; hi/lo written; done=1 for the cycle following E33.
  - busy is high for the cycles after E0 through the cycle ending at E33, i.e. 33 cycles.
- Multiply (shift-add):
  - 2*WIDTH accumulator.
  - {hi,lo} = product.
  - Signed: negate the 64-bit magnitude when a[31]^b[31].
- Divide (restoring):
  - lo = quotient, hi = remainder.
  - Signed: quotient negated when a[31]^b[31]; remainder takes the sign of the dividend.
  - Magnitude of 0x80000000 is treated as unsigned 0x80000000, so -2^31 / -1 gives lo=0x80000000, hi=0.
- Divide by zero:
  - Result is lo=all ones and hi=a (raw operand), for both signed and unsigned.
  - Sign correction is skipped.
  - div_by_zero=1 together with done.
- Start while busy: ignored; no state change; the hazard unit must not issue it.
- abort: in CALC or FIX, returns to IDLE at the next edge. hi/lo are unchanged and no done pulse occurs. In IDLE, abort has no effect.
- abort together with start in IDLE: abort wins and start is dropped.
- mthi/mtlo:
  - In IDLE, we_hi/we_lo write wd at the edge.
  - While busy, writes are ignored.
  - If start and a write arrive in the same IDLE cycle, the write takes effect and the operation result later overwrites both hi and lo.
- done and div_by_zero are registered pulses, low in all other cycles.
- Counter wraps never occur: it is cleared on entry to CALC and compared to WIDTH-1.

Decomposition:
- Package muldiv_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIX=2'd2;
  - default WIDTH;
  - the divide-by-zero LO constant.
- One natural sub-module, muldiv_step: combinational single iteration. Inputs are mode, accumulator and operand; outputs are the next accumulator, for both add-shift and restoring subtract-shift. It is instantiated once inside muldiv_iter_unit.
- Sign/abs handling stays inline.

Test Plan:
- Signed multiply: mult a=0xFFFFFFFD (-3), b=7 -> busy high 33 cycles; done pulse in the cycle after E33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned multiply: multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed mult of the same operands -> hi=0, lo=1.
- Divide sign rules:
  - div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 100/7 -> lo=14, hi=2.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: divu a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678; div_by_zero=1 coincident with done.
- Control corners:
  - Second start at cycle 5 of busy is ignored (done occurs exactly once).
  - abort at cycle 10 -> busy=0 next cycle, no done, hi/lo keep the prior values.
  - rst asserted mid-CALC -> immediately busy=0, hi=lo=0.
- mthi/mtlo: we_hi with wd=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5; we_lo while busy -> lo unchanged and the operation result lands at E33.
